// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, radix-2 Booth multiplier
// and non-restoring divider, returning a double-width {HI,LO} result.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [12:0]        control,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               err_op,
    output logic               err_dz
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MUL_IT  = 3'd1;
    localparam logic [2:0] DIV_IT  = 3'd2;
    localparam logic [2:0] DIV_FIX = 3'd3;
    localparam logic [2:0] FIN     = 3'd4;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    logic [2:0]         r_state;
    logic [SHW-1:0]     r_cnt;
    logic               r_busy;
    logic               r_err_op;
    logic               r_err_dz;
    logic [12:0]        r_ctrl;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_c;
    logic [2*WIDTH+1:0] r_p;
    logic [WIDTH+1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               w_onehot;
    logic               w_big;
    logic [SHW-1:0]     w_sh;
    logic [SHW-1:0]     w_rsh;
    logic [WIDTH-1:0]   w_rot;
    logic [WIDTH-1:0]   w_sra;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_p_sum;
    logic [2*WIDTH+1:0] w_p_next;
    logic [WIDTH+1:0]   w_r2;
    logic [WIDTH+1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_div_c;

    assign w_onehot = $onehot(r_ctrl);
    assign w_big    = |r_b[WIDTH-1:SHW];
    assign w_sh     = r_b[SHW-1:0];
    assign w_sra    = $signed(r_a) >>> w_sh;
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    // ROL by s is ROR by -s modulo WIDTH, so one rotator serves both.
    assign w_rsh    = r_ctrl[10] ? -w_sh : w_sh;

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < WIDTH; i++) w_rot[i] = r_a[SHW'(i) + w_rsh];
    end

    assign w_lo = r_ctrl[0] ? r_a & r_b :
                  r_ctrl[1] ? r_a | r_b :
                  r_ctrl[2] ? w_sum[WIDTH-1:0] :
                  r_ctrl[3] ? r_a - r_b :
                  r_ctrl[6] ? (w_big ? '0 : r_a >> w_sh) :
                  r_ctrl[7] ? (w_big ? {WIDTH{r_a[WIDTH-1]}} : w_sra) :
                  r_ctrl[8] ? (w_big ? '0 : r_a << w_sh) :
                  (r_ctrl[9] || r_ctrl[10]) ? w_rot :
                  r_ctrl[11] ? -r_b : ~r_b;
    assign w_hi = r_ctrl[2] ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH]} : '0;

    // Booth accumulator is one bit wider than the operand so MIN*MIN cannot overflow.
    assign w_m_ext  = {r_a[WIDTH-1], r_a};
    assign w_p_sum  = (r_p[1:0] == 2'b01) ? r_p[2*WIDTH+1:WIDTH+1] + w_m_ext :
                      (r_p[1:0] == 2'b10) ? r_p[2*WIDTH+1:WIDTH+1] - w_m_ext :
                      r_p[2*WIDTH+1:WIDTH+1];
    assign w_p_next = {w_p_sum[WIDTH], w_p_sum, r_p[WIDTH:1]};

    // Divider iterates on magnitudes; signs are restored in DIV_FIX.
    assign w_abs_a    = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_abs_b    = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_r2       = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
    assign w_rem_next = r_rem[WIDTH+1] ? w_r2 + {2'b00, r_dvs} : w_r2 - {2'b00, r_dvs};
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_rem_next[WIDTH+1]};
    assign w_rem_mag  = r_rem[WIDTH+1] ? r_rem[WIDTH-1:0] + r_dvs : r_rem[WIDTH-1:0];
    assign w_div_c    = {r_a[WIDTH-1] ? -w_rem_mag : w_rem_mag,
                         (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_quo : r_quo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_err_op <= 1'b0;
            r_err_dz <= 1'b0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_p      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else begin
            if (!r_busy && start) begin
                r_a      <= A;
                r_b      <= B;
                r_ctrl   <= control;
                r_busy   <= 1'b1;
                r_err_op <= 1'b0;
                r_err_dz <= 1'b0;
            end
            case (r_state)
                IDLE: if (r_busy) begin
                    if (w_onehot && r_ctrl[4]) begin
                        r_state <= MUL_IT;
                        r_p     <= {{(WIDTH+1){1'b0}}, r_b, 1'b0};
                    end else if (w_onehot && r_ctrl[5] && r_b != '0) begin
                        r_state <= DIV_IT;
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                    end else begin
                        r_state  <= FIN;
                        r_busy   <= 1'b0;
                        r_c      <= !w_onehot ? '0 : r_ctrl[5] ? {r_a, {WIDTH{1'b1}}} : {w_hi, w_lo};
                        r_err_op <= !w_onehot;
                        r_err_dz <= w_onehot && r_ctrl[5];
                    end
                end
                MUL_IT: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_c     <= w_p_next[2*WIDTH:1];
                    end
                end
                DIV_IT: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= DIV_FIX;
                        r_cnt   <= '0;
                    end
                end
                DIV_FIX: begin
                    r_state <= FIN;
                    r_busy  <= 1'b0;
                    r_c     <= w_div_c;
                end
                FIN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign C      = r_c;
    assign busy   = r_busy;
    assign done   = (r_state == FIN);
    assign err_op = r_err_op;
    assign err_dz = r_err_dz;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, handshake corner sequences and random ops against an
// arithmetic reference model, on 32-bit and 16-bit instances.
module tb_alu_seq;
    localparam logic [12:0] OP_AND  = 13'h0001;
    localparam logic [12:0] OP_OR   = 13'h0002;
    localparam logic [12:0] OP_ADD  = 13'h0004;
    localparam logic [12:0] OP_SUB  = 13'h0008;
    localparam logic [12:0] OP_MUL  = 13'h0010;
    localparam logic [12:0] OP_DIV  = 13'h0020;
    localparam logic [12:0] OP_SHR  = 13'h0040;
    localparam logic [12:0] OP_SHRA = 13'h0080;
    localparam logic [12:0] OP_SHL  = 13'h0100;
    localparam logic [12:0] OP_ROR  = 13'h0200;
    localparam logic [12:0] OP_ROL  = 13'h0400;
    localparam logic [12:0] OP_NEG  = 13'h0800;
    localparam logic [12:0] OP_NOT  = 13'h1000;

    typedef struct {
        int          w;
        logic [12:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic        eo;
        logic        ed;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start16 = 1'b0;
    logic [12:0] control = '0;
    logic [12:0] control16 = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [15:0] A16 = '0;
    logic [15:0] B16 = '0;
    logic [63:0] C;
    logic [31:0] C16;
    logic        busy, done, err_op, err_dz;
    logic        busy16, done16, err_op16, err_dz16;
    int          n_pass = 0;
    int          n_tot = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control), .A(A), .B(B),
        .C(C), .busy(busy), .done(done), .err_op(err_op), .err_dz(err_dz));

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .control(control16), .A(A16), .B(B16),
        .C(C16), .busy(busy16), .done(done16), .err_op(err_op16), .err_dz(err_dz16));

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endfunction

    function automatic void model(input int w, input logic [12:0] ctrl, input logic [31:0] a,
                                  input logic [31:0] b, output logic [63:0] c, output logic eo,
                                  output logic ed, output int lat);
        longint m, ua, ub, sa, sb, lo, hi, s;
        m  = (longint'(1) << w) - 1;
        ua = longint'({32'h0, a}) & m;
        ub = longint'({32'h0, b}) & m;
        sa = ua[w-1] ? ua - (m + 1) : ua;
        sb = ub[w-1] ? ub - (m + 1) : ub;
        s  = ub % w;
        lo = 0; hi = 0; eo = 1'b0; ed = 1'b0; lat = 1;
        if ($countones(ctrl) != 1) eo = 1'b1;
        else if (ctrl[0]) lo = ua & ub;
        else if (ctrl[1]) lo = ua | ub;
        else if (ctrl[2]) begin lo = ua + ub; hi = lo >> w; end
        else if (ctrl[3]) lo = ua - ub;
        else if (ctrl[4]) begin lo = sa * sb; hi = lo >>> w; lat = w + 1; end
        else if (ctrl[5]) begin
            if (ub == 0) begin lo = m; hi = ua; ed = 1'b1; end
            else begin lo = sa / sb; hi = sa % sb; lat = w + 2; end
        end
        else if (ctrl[6]) lo = (ub >= w) ? 0 : ua >> ub;
        else if (ctrl[7]) lo = (ub >= w) ? (sa < 0 ? m : 0) : sa >>> ub;
        else if (ctrl[8]) lo = (ub >= w) ? 0 : ua << ub;
        else if (ctrl[9]) lo = (ua >> s) | (ua << (w - s));
        else if (ctrl[10]) lo = (ua << s) | (ua >> (w - s));
        else if (ctrl[11]) lo = -ub;
        else lo = ~ub;
        c = 64'(((hi & m) << w) | (lo & m));
    endfunction

    task automatic run_op(input int w, input logic [12:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] c, output logic eo,
                          output logic ed, output int lat);
        @(negedge clk);
        if (w == 32) begin start = 1'b1; control = ctrl; A = a; B = b; end
        else begin start16 = 1'b1; control16 = ctrl; A16 = a[15:0]; B16 = b[15:0]; end
        @(posedge clk);
        #1;
        start = 1'b0;
        start16 = 1'b0;
        A = $urandom; B = $urandom; control = 13'($urandom);
        A16 = 16'($urandom); B16 = 16'($urandom); control16 = 13'($urandom);
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if ((w == 32) ? done : done16) begin lat = n; break; end
        end
        c  = (w == 32) ? C : {32'h0, C16};
        eo = (w == 32) ? err_op : err_op16;
        ed = (w == 32) ? err_dz : err_dz16;
    endtask

    task automatic check_op(input string nm, input vec_t v);
        logic [63:0] c;
        logic        eo, ed;
        int          lat;
        run_op(v.w, v.ctrl, v.a, v.b, c, eo, ed, lat);
        chk({nm, ".lat"}, 64'(lat), 64'(v.lat));
        chk({nm, ".C"}, c, v.c);
        chk({nm, ".err_op"}, 64'(eo), 64'(v.eo));
        chk({nm, ".err_dz"}, 64'(ed), 64'(v.ed));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          nb, nd, lat;
        logic [63:0] cap;
        tbl.push_back('{32, OP_ADD,  32'hFFFFFFFF, 32'h1,        64'h00000001_00000000, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_ROR,  32'h80000001, 32'd33,       64'h00000000_C0000000, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_MUL,  32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6, 1'b0, 1'b0, 33});
        tbl.push_back('{32, OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b0, 33});
        tbl.push_back('{32, OP_DIV,  32'hFFFFFFEF, 32'd5,        64'hFFFFFFFE_FFFFFFFD, 1'b0, 1'b0, 34});
        tbl.push_back('{32, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, 34});
        tbl.push_back('{32, OP_DIV,  32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b0, 1'b1, 1});
        tbl.push_back('{32, OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_00F000F0, 1'b0, 1'b0, 1});
        tbl.push_back('{32, 13'h0003, 32'h12345678, 32'h9,       64'h0,                 1'b1, 1'b0, 1});
        tbl.push_back('{32, 13'h0000, 32'h12345678, 32'h9,       64'h0,                 1'b1, 1'b0, 1});
        tbl.push_back('{32, OP_NEG,  32'h0,        32'h80000000, 64'h00000000_80000000, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SUB,  32'd5,        32'd7,        64'h00000000_FFFFFFFE, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SHL,  32'h1,        32'd32,       64'h0,                 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SHR,  32'h80000000, 32'd31,       64'h00000000_00000001, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SHR,  32'h80000000, 32'h100,      64'h0,                 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SHRA, 32'h80000000, 32'd40,       64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_SHRA, 32'h80000000, 32'd4,        64'h00000000_F8000000, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_ROL,  32'h80000001, 32'd0,        64'h00000000_80000001, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_ROL,  32'h80000001, 32'd4,        64'h00000000_00000018, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_NOT,  32'hFFFFFFFF, 32'h0F0F0F0F, 64'h00000000_F0F0F0F0, 1'b0, 1'b0, 1});
        tbl.push_back('{32, OP_OR,   32'h12340000, 32'h00005678, 64'h00000000_12345678, 1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_SHRA, 32'h8000,     32'd20,       64'h0000FFFF,          1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_SHRA, 32'h4000,     32'd20,       64'h0,                 1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_SHR,  32'h8000,     32'd16,       64'h0,                 1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_SHL,  32'h0001,     32'd15,       64'h00008000,          1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_ROR,  32'h0001,     32'd17,       64'h00008000,          1'b0, 1'b0, 1});
        tbl.push_back('{16, OP_ROL,  32'h8000,     32'd1,        64'h00000001,          1'b0, 1'b0, 1});

        repeat (3) @(posedge clk);
        #1;
        chk("rst.C", C, 64'h0);
        chk("rst.busy", 64'(busy), 64'h0);
        chk("rst.done", 64'(done), 64'h0);
        chk("rst.err_op", 64'(err_op), 64'h0);
        chk("rst.err_dz", 64'(err_dz), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) check_op($sformatf("vec%0d", i), tbl[i]);

        // Second start during a MUL must be ignored.
        @(negedge clk);
        start = 1'b1; control = OP_MUL; A = 32'hFFFFFFF9; B = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        nb = busy ? 1 : 0;
        nd = 0;
        lat = -1;
        cap = '0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 6) begin start = 1'b1; control = OP_ADD; A = 32'd1; B = 32'd2; end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy) nb++;
            if (done) begin nd++; if (lat < 0) lat = n; cap = C; end
        end
        chk("ign.dones", 64'(nd), 64'd1);
        chk("ign.lat", 64'(lat), 64'd33);
        chk("ign.busy_cycles", 64'(nb), 64'd33);
        chk("ign.C", cap, 64'hFFFFFFFF_FFFFFFD6);

        // Reset in the middle of a DIV aborts it.
        @(negedge clk);
        start = 1'b1; control = OP_DIV; A = 32'hFFFFFFEF; B = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.C", C, 64'h0);
        chk("abort.busy", 64'(busy), 64'h0);
        chk("abort.done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort.no_done", 64'(nd), 64'd0);

        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? 32 : 16;
            for (int i = 0; i < ((k == 0) ? 150 : 60); i++) begin
                int   op;
                vec_t v;
                op = $urandom_range(0, 13);
                v.w = w;
                v.ctrl = (op == 13) ? 13'($urandom) : 13'(1) << op;
                v.a = ($urandom_range(0, 7) == 0) ? ((w == 32) ? 32'h80000000 : 32'h8000) : $urandom;
                v.b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 2 * w + 6)) : $urandom;
                model(w, v.ctrl, v.a, v.b, v.c, v.eo, v.ed, v.lat);
                check_op($sformatf("rnd_w%0d_%0d_op%0d", w, i, op), v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
